// File: rtl/pipe_reg_ar.sv
// pipe_reg_ar: elastic pipeline register, DEPTH stages of WIDTH-bit data, each with a valid bit.
// Latency: DEPTH cycles from input handshake to out_valid on an empty pipe, 1 word/cycle sustained.
// Backpressure: bubbles collapse toward the output; in_ready drops only when every stage ahead is full.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (clears valids, data <= RESET_VAL)
//   flush      synchronous clear of all valid bits; blocks both handshakes while high
//   in_valid / in_data / in_ready     upstream valid/ready interface
//   out_valid / out_data / out_ready  downstream valid/ready interface
//   count      number of valid stages (popcount of the valid register)
module pipe_reg_ar #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [DEPTH-1:0]            rdy;
  logic                        all_v;
  logic [CW-1:0]               cnt;

  // A stage is ready when it is empty or everything downstream of it moves.
  // Equivalently: not all of stages k..DEPTH-1 are valid, or the sink pops.
  // Written as a running AND so the chain does not feed back on itself.
  always_comb begin
    all_v = 1'b1;
    rdy   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      all_v  = all_v & v_q[k];
      rdy[k] = ~all_v | out_ready;
    end
  end

  // Data registers load only alongside a valid bit, so bubbles never toggle them.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (rdy[0]) begin
        v_d[0] = in_valid;
        if (in_valid) d_d[0] = in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) d_d[k] = d_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      d_q <= {DEPTH{RESET_VAL}};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  // count depends only on registered valids.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + CW'(v_q[k]);
    end
  end

  assign count     = cnt;
  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v_q[DEPTH-1] & ~flush;
  assign out_data  = d_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_ar.sv
`timescale 1ns/1ps
// tb_pipe_reg_ar: directed vectors plus a queue scoreboard for pipe_reg_ar (WIDTH=8, DEPTH=3).
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
// Every comparison goes through check().
module tb_pipe_reg_ar;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [1:0] count;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  pipe_reg_ar #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1ns past the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: words accepted but not yet delivered. Its size must equal count.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
    end else begin
      check("count_vs_sb", 32'(count), 32'(sb.size()));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else                check("sb_order", 32'(out_data), 32'(sb.pop_front()));
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      if (flush) sb.delete();
    end
  end

  // One word into an empty pipe with out_ready=1: out_valid exactly in the 3rd cycle after.
  task automatic latency(input logic [7:0] w, input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check({tag, "_out_valid"}, 32'(out_valid), (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) check({tag, "_out_data"}, 32'(out_data), 32'(w));
      cyc();
    end
  endtask

  initial begin
    int idx;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;

    // ---- 1. reset mid-operation, asynchronous ----
    in_valid = 1'b1; in_data = 8'h77; cyc();
    in_data  = 8'h88; cyc();
    in_valid = 1'b0;
    #1;
    check("pre_reset_count", 32'(count), 32'd2);
    #1;
    reset_n   = 1'b0;
    in_valid  = 1'($urandom);
    in_data   = 8'($urandom);
    out_ready = 1'($urandom);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    cyc();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    cyc();

    // ---- 2. latency ----
    latency(8'hA5, "lat");

    // ---- 3. back-pressure with a holding source ----
    out_ready = 1'b0;
    idx = 1;
    for (int t = 0; t < 5; t++) begin
      in_valid = 1'b1;
      in_data  = 8'(idx);
      #1;
      check("bp_in_ready", 32'(in_ready), (t < 3) ? 32'd1 : 32'd0);
      if (in_ready) idx++;
      cyc();
    end
    #1;
    check("bp_count_full", 32'(count), 32'd3);
    check("bp_idx", 32'(idx), 32'd4);
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      if (idx <= 5) begin in_valid = 1'b1; in_data = 8'(idx); end
      else          in_valid = 1'b0;
      #1;
      check("bp_drain_valid", 32'(out_valid), 32'd1);
      check("bp_drain_data",  32'(out_data),  32'(t + 1));
      if (t < 2) check("bp_pushpop_count", 32'(count), 32'd3);
      if (in_valid && in_ready) idx++;
      cyc();
    end
    in_valid = 1'b0;
    #1;
    check("bp_empty_count", 32'(count), 32'd0);
    cyc();

    // ---- 4. streaming 20 words ----
    out_ready = 1'b1;
    for (int c = 0; c < 23; c++) begin
      in_valid = (c < 20);
      in_data  = 8'(8'h40 + c);
      #1;
      check("st_in_ready", 32'(in_ready), 32'd1);
      if (c >= 3) begin
        check("st_out_valid", 32'(out_valid), 32'd1);
        check("st_out_data",  32'(out_data),  32'(8'h40 + c - 3));
      end
      if (c >= 3 && c < 20) check("st_count", 32'(count), 32'd3);
      cyc();
    end
    in_valid = 1'b0;
    cyc();

    // ---- 5. flush ----
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 8'h11; cyc();
    in_data = 8'h22; cyc();
    in_data = 8'h33; cyc();
    #1;
    check("fl_count_full", 32'(count), 32'd3);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 8'h44;
    #1;
    check("fl_in_ready",  32'(in_ready),  32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_count_after", 32'(count), 32'd0);
    check("fl_out_valid_after", 32'(out_valid), 32'd0);
    latency(8'h5A, "fl_lat");

    // ---- 6. random traffic with one mid-stream reset ----
    for (int c = 0; c < 1000; c++) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = 1'($urandom);
      if (c == 500) begin
        #2;
        reset_n = 1'b0;
        #1;
        check("rnd_rst_count",     32'(count),     32'd0);
        check("rnd_rst_out_valid", 32'(out_valid), 32'd0);
        cyc();
        reset_n = 1'b1;
      end else begin
        cyc();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) cyc();
    #1;
    check("rnd_final_count", 32'(count), 32'd0);
    check("rnd_final_sb",    32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
